estagio_id_ex: RTL and testbench

ID/EX pipeline stage placed directly downstream of the register bank. It captures the decoded instruction, the two register-bank read values and the control bits, and presents them to the execute stage one cycle later. It detects load-use hazards, stalls the IF/ID stages and inserts a bubble into EX. It also honours flush (branch/jump redirect) and downstream hold requests, and counts inserted hazard bubbles.

---
 rtl/estagio_id_ex.sv | 132 +++++++++++++
 tb/tb_estagio_id_ex.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register. Captures the decoded instruction plus the register
// bank read values, detects load-use hazards (stalling IF/ID and inserting a
// bubble into EX), honours flush and downstream hold, and counts bubbles.
module estagio_id_ex #(
  parameter int unsigned LARGURA_DADO     = 32,
  parameter int unsigned LARGURA_CONTADOR = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        valid_id,
  input  logic [LARGURA_DADO-1:0]     pc_id,
  input  logic [4:0]                  rs_id,
  input  logic [4:0]                  rt_id,
  input  logic [4:0]                  rd_id,
  input  logic                        usa_rt_id,
  input  logic [LARGURA_DADO-1:0]     dado_rs_id,
  input  logic [LARGURA_DADO-1:0]     dado_rt_id,
  input  logic [LARGURA_DADO-1:0]     imediato_id,
  input  logic                        escreve_reg_id,
  input  logic                        le_mem_id,
  input  logic                        escreve_mem_id,
  input  logic                        usa_imediato_id,
  input  logic [3:0]                  ula_op_id,
  input  logic                        flush,
  input  logic                        stall_externo,
  output logic                        valid_ex,
  output logic [LARGURA_DADO-1:0]     pc_ex,
  output logic [4:0]                  rs_ex,
  output logic [4:0]                  rt_ex,
  output logic [4:0]                  rd_ex,
  output logic [LARGURA_DADO-1:0]     dado_rs_ex,
  output logic [LARGURA_DADO-1:0]     dado_rt_ex,
  output logic [LARGURA_DADO-1:0]     imediato_ex,
  output logic                        escreve_reg_ex,
  output logic                        le_mem_ex,
  output logic                        escreve_mem_ex,
  output logic                        usa_imediato_ex,
  output logic [3:0]                  ula_op_ex,
  output logic                        stall_id,
  output logic [LARGURA_CONTADOR-1:0] contador_bolhas
);

  typedef struct packed {
    logic                    valid;
    logic [LARGURA_DADO-1:0] pc;
    logic [4:0]              rs;
    logic [4:0]              rt;
    logic [4:0]              rd;
    logic [LARGURA_DADO-1:0] dado_rs;
    logic [LARGURA_DADO-1:0] dado_rt;
    logic [LARGURA_DADO-1:0] imediato;
    logic                    escreve_reg;
    logic                    le_mem;
    logic                    escreve_mem;
    logic                    usa_imediato;
    logic [3:0]              ula_op;
  } campos_t;

  campos_t                     ex_q, ex_d, carga;
  logic [LARGURA_CONTADOR-1:0] contador_q, contador_d;
  logic                        risco;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  assign risco = ex_q.valid & ex_q.le_mem & ex_q.escreve_reg & (ex_q.rd != 5'd0) & valid_id &
                 ((rs_id == ex_q.rd) | (usa_rt_id & (rt_id == ex_q.rd)));

  // Stall is held low during reset so upstream stages are not frozen by it.
  assign stall_id = reset & (risco | stall_externo);

  // Fields presented for a normal load; an invalid slot carries no side effects.
  always_comb begin
    carga              = '0;
    carga.valid        = valid_id;
    carga.pc           = pc_id;
    carga.rs           = rs_id;
    carga.rt           = rt_id;
    carga.rd           = rd_id;
    carga.dado_rs      = dado_rs_id;
    carga.dado_rt      = dado_rt_id;
    carga.imediato     = imediato_id;
    carga.escreve_reg  = valid_id & escreve_reg_id;
    carga.le_mem       = valid_id & le_mem_id;
    carga.escreve_mem  = valid_id & escreve_mem_id;
    carga.usa_imediato = valid_id & usa_imediato_id;
    carga.ula_op       = ula_op_id;
  end

  // Next EX contents and counter: flush > external hold > bubble > load.
  always_comb begin
    ex_d       = ex_q;
    contador_d = contador_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall_externo) begin
      ex_d = ex_q;
    end else if (risco) begin
      ex_d = '0;
      if (contador_q != '1) begin
        contador_d = contador_q + LARGURA_CONTADOR'(1);
      end
    end else begin
      ex_d = carga;
    end
  end

  // Pipeline register and saturating bubble counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q       <= '0;
      contador_q <= '0;
    end else begin
      ex_q       <= ex_d;
      contador_q <= contador_d;
    end
  end

  assign valid_ex        = ex_q.valid;
  assign pc_ex           = ex_q.pc;
  assign rs_ex           = ex_q.rs;
  assign rt_ex           = ex_q.rt;
  assign rd_ex           = ex_q.rd;
  assign dado_rs_ex      = ex_q.dado_rs;
  assign dado_rt_ex      = ex_q.dado_rt;
  assign imediato_ex     = ex_q.imediato;
  assign escreve_reg_ex  = ex_q.escreve_reg;
  assign le_mem_ex       = ex_q.le_mem;
  assign escreve_mem_ex  = ex_q.escreve_mem;
  assign usa_imediato_ex = ex_q.usa_imediato;
  assign ula_op_ex       = ex_q.ula_op;
  assign contador_bolhas = contador_q;

endmodule

// File: tb/tb_estagio_id_ex.sv
// Randomized and directed bench for estagio_id_ex against a behavioural model
// of the EX slot and the bubble counter.
module tb_estagio_id_ex;

  localparam int unsigned LD  = 32;
  localparam int unsigned LC  = 4;
  localparam int          MAX = (1 << LC) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          valid_id, usa_rt_id, flush, stall_externo;
  logic [LD-1:0] pc_id, dado_rs_id, dado_rt_id, imediato_id;
  logic [4:0]    rs_id, rt_id, rd_id;
  logic          escreve_reg_id, le_mem_id, escreve_mem_id, usa_imediato_id;
  logic [3:0]    ula_op_id;
  logic          valid_ex, escreve_reg_ex, le_mem_ex, escreve_mem_ex, usa_imediato_ex, stall_id;
  logic [LD-1:0] pc_ex, dado_rs_ex, dado_rt_ex, imediato_ex;
  logic [4:0]    rs_ex, rt_ex, rd_ex;
  logic [3:0]    ula_op_ex;
  logic [LC-1:0] contador_bolhas;

  estagio_id_ex #(.LARGURA_DADO(LD), .LARGURA_CONTADOR(LC)) dut (
    .clock(clock), .reset(reset), .valid_id(valid_id), .pc_id(pc_id), .rs_id(rs_id),
    .rt_id(rt_id), .rd_id(rd_id), .usa_rt_id(usa_rt_id), .dado_rs_id(dado_rs_id),
    .dado_rt_id(dado_rt_id), .imediato_id(imediato_id), .escreve_reg_id(escreve_reg_id),
    .le_mem_id(le_mem_id), .escreve_mem_id(escreve_mem_id),
    .usa_imediato_id(usa_imediato_id), .ula_op_id(ula_op_id), .flush(flush),
    .stall_externo(stall_externo), .valid_ex(valid_ex), .pc_ex(pc_ex), .rs_ex(rs_ex),
    .rt_ex(rt_ex), .rd_ex(rd_ex), .dado_rs_ex(dado_rs_ex), .dado_rt_ex(dado_rt_ex),
    .imediato_ex(imediato_ex), .escreve_reg_ex(escreve_reg_ex), .le_mem_ex(le_mem_ex),
    .escreve_mem_ex(escreve_mem_ex), .usa_imediato_ex(usa_imediato_ex),
    .ula_op_ex(ula_op_ex), .stall_id(stall_id), .contador_bolhas(contador_bolhas)
  );

  always #5 clock = ~clock;

  // Model of the instruction sitting in EX.
  typedef struct packed {
    logic          valid;
    logic [LD-1:0] pc;
    logic [4:0]    rs, rt, rd;
    logic [LD-1:0] drs, drt, imm;
    logic          er, lm, em, ui;
    logic [3:0]    ula;
  } ex_t;

  ex_t m;
  int  m_cont;
  int  n_verif = 0;
  int  n_falhas = 0;

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_verif++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  // A load in EX whose destination the ID instruction reads.
  function automatic logic risco_m();
    logic le_dest;
    le_dest = (rs_id == m.rd) || (usa_rt_id && rt_id == m.rd);
    return m.valid && m.lm && m.er && (m.rd != 0) && valid_id && le_dest;
  endfunction

  task automatic atualiza_modelo(input logic r);
    if (flush) m = '0;
    else if (stall_externo) m = m;
    else if (r) begin
      m = '0;
      if (m_cont < MAX) m_cont++;
    end else begin
      m.valid = valid_id;   m.pc = pc_id;
      m.rs = rs_id;         m.rt = rt_id;         m.rd = rd_id;
      m.drs = dado_rs_id;   m.drt = dado_rt_id;   m.imm = imediato_id;
      m.er = valid_id & escreve_reg_id;  m.lm = valid_id & le_mem_id;
      m.em = valid_id & escreve_mem_id;  m.ui = valid_id & usa_imediato_id;
      m.ula = ula_op_id;
    end
  endtask

  task automatic verifica_ex();
    verifica("valid_ex", valid_ex, m.valid);
    verifica("pc_ex", pc_ex, m.pc);
    verifica("regs_ex", {rs_ex, rt_ex, rd_ex}, {m.rs, m.rt, m.rd});
    verifica("dado_rs_ex", dado_rs_ex, m.drs);
    verifica("dado_rt_ex", dado_rt_ex, m.drt);
    verifica("imediato_ex", imediato_ex, m.imm);
    verifica("ctrl_ex", {escreve_reg_ex, le_mem_ex, escreve_mem_ex, usa_imediato_ex},
             {m.er, m.lm, m.em, m.ui});
    if (m.valid) verifica("ula_op_ex", ula_op_ex, m.ula);
    verifica("contador", contador_bolhas, m_cont);
  endtask

  // One clock: check stall mid-cycle, advance model at the edge, check EX after.
  task automatic ciclo();
    logic r;
    @(negedge clock);
    r = risco_m();
    verifica("stall_id", stall_id, r | stall_externo);
    @(posedge clock);
    atualiza_modelo(r);
    #1;
    verifica_ex();
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urt, input logic [LD-1:0] drs,
                       input logic [LD-1:0] drt, input logic er, input logic lm,
                       input logic [3:0] ula);
    valid_id = v;  pc_id = $urandom;  rs_id = rs;  rt_id = rt;  rd_id = rd;
    usa_rt_id = urt;  dado_rs_id = drs;  dado_rt_id = drt;  imediato_id = $urandom;
    escreve_reg_id = er;  le_mem_id = lm;  escreve_mem_id = 1'b0;
    usa_imediato_id = lm;  ula_op_id = ula;
  endtask

  task automatic aplica_reset();
    reset = 1'b0;
    m = '0;
    m_cont = 0;
    #1;
    verifica("reset_valid", valid_ex, 1'b0);
    verifica("reset_cont", contador_bolhas, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int c0;
    flush = 1'b0;
    stall_externo = 1'b0;
    instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, '0, 1'b0, 1'b0, 4'h0);
    aplica_reset();
    verifica_ex();

    // Asynchronous reset mid-cycle, with stall_externo high to see it masked.
    instr(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 4'h2);
    ciclo();
    verifica("pre_reset_valid", valid_ex, 1'b1);
    stall_externo = 1'b1;
    #2 reset = 1'b0;
    #1;
    verifica("async_valid", valid_ex, 1'b0);
    verifica("async_dado_rs", dado_rs_ex, 32'h0);
    verifica("async_stall", stall_id, 1'b0);
    m = '0;
    m_cont = 0;
    stall_externo = 1'b0;
    #1 reset = 1'b1;

    // Normal flow.
    instr(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 4'h2);
    ciclo();
    verifica("normal_drs", dado_rs_ex, 32'h11);
    verifica("normal_drt", dado_rt_ex, 32'h22);
    verifica("normal_ula", ula_op_ex, 4'h2);

    // Load-use on rs.
    instr(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 32'h1, 32'h2, 1'b1, 1'b1, 4'h0);
    ciclo();
    instr(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 32'h55, 32'h66, 1'b1, 1'b0, 4'h2);
    #1 verifica("lu_stall", stall_id, 1'b1);
    ciclo();
    verifica("lu_bolha", valid_ex, 1'b0);
    verifica("lu_cont", contador_bolhas, 1);
    #1 verifica("lu_sem_stall", stall_id, 1'b0);
    ciclo();
    verifica("lu_add_rs", {valid_ex, rs_ex}, {1'b1, 5'd5});

    // Load to $0, then use of $0: no hazard.
    instr(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'h1, 32'h2, 1'b1, 1'b1, 4'h0);
    ciclo();
    instr(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 4'h2);
    #1 verifica("zero_stall", stall_id, 1'b0);
    ciclo();
    verifica("zero_cont", contador_bolhas, 1);

    // rt match without usa_rt: no hazard.
    instr(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 32'h1, 32'h2, 1'b1, 1'b1, 4'h0);
    ciclo();
    instr(1'b1, 5'd3, 5'd5, 5'd9, 1'b0, 32'h3, 32'h5, 1'b1, 1'b0, 4'h2);
    #1 verifica("rt_sem_uso_stall", stall_id, 1'b0);
    ciclo();

    // Flush together with a hazard: cleared, counter unchanged.
    instr(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 32'h1, 32'h2, 1'b1, 1'b1, 4'h0);
    ciclo();
    c0 = m_cont;
    instr(1'b1, 5'd6, 5'd2, 5'd9, 1'b1, 32'h6, 32'h2, 1'b1, 1'b0, 4'h2);
    flush = 1'b1;
    ciclo();
    flush = 1'b0;
    verifica("flush_valid", valid_ex, 1'b0);
    verifica("flush_cont", contador_bolhas, c0);

    // External hold for three cycles, also over a pending hazard.
    instr(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 32'hA, 32'hB, 1'b1, 1'b1, 4'h0);
    ciclo();
    instr(1'b1, 5'd6, 5'd2, 5'd9, 1'b1, 32'h6, 32'h2, 1'b1, 1'b0, 4'h2);
    stall_externo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      verifica("hold_drs", dado_rs_ex, 32'hA);
      verifica("hold_stall", stall_id, 1'b1);
    end
    verifica("hold_cont", contador_bolhas, c0);
    stall_externo = 1'b0;
    ciclo();
    ciclo();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      instr(($urandom_range(0, 99) < 85), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom, 1'($urandom),
            ($urandom_range(0, 99) < 40), 4'($urandom));
      escreve_mem_id = 1'($urandom);
      usa_imediato_id = 1'($urandom);
      flush = ($urandom_range(0, 99) < 8);
      stall_externo = ($urandom_range(0, 99) < 15);
      ciclo();
    end
    flush = 1'b0;
    stall_externo = 1'b0;

    // Saturation: 17 load-use bubbles from a cleared counter.
    aplica_reset();
    for (int i = 0; i < 17; i++) begin
      instr(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 32'h1, 32'h2, 1'b1, 1'b1, 4'h0);
      ciclo();
      instr(1'b1, 5'd5, 5'd2, 5'd9, 1'b0, 32'h5, 32'h2, 1'b1, 1'b0, 4'h2);
      ciclo();
      ciclo();
    end
    verifica("saturacao", contador_bolhas, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_verif, n_falhas);
    $finish;
  end

endmodule
